// File: rtl/alarm_controller.sv
// Alarm controller: compares running time with the alarm time and drives the buzzer via ARMED/RINGING/SNOOZING FSM.
// Latency: outputs registered from next-state; ringing rises one clk after the trigger cycle.
// Backpressure: none; button and tick pulses are consumed in the cycle they arrive.
//
// Ports:
//   clk, reset (async active-low)       - clock and reset
//   sec_tick                            - 1 Hz single-cycle pulse
//   seconds/minutes/hours               - running time
//   alarm_minutes/alarm_hours, alarm_en - programmed alarm and arm level
//   snooze_btn, stop_btn                - debounced single-cycle pulses
//   ringing, snooze_active, buzzer      - registered status and buzzer drive
// Optional build macro: ALARM_BUZZER_PULSE_EN (buzzer pulses at 0.5 Hz while ringing).
module alarm_controller #(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_MINUTES = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    input  logic [4:0] hours,
    input  logic [5:0] alarm_minutes,
    input  logic [4:0] alarm_hours,
    input  logic       alarm_en,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       ringing,
    output logic       snooze_active,
    output logic       buzzer
);

    localparam int SNOOZE_TICKS = SNOOZE_MINUTES * 60;
    localparam int RW           = $clog2(RING_SECONDS + 1);
    localparam int SW           = $clog2(SNOOZE_TICKS + 1);

    localparam logic [RW-1:0] RING_LAST   = RW'(RING_SECONDS - 1);
    localparam logic [RW-1:0] RING_MAX    = RW'(RING_SECONDS);
    localparam logic [SW-1:0] SNOOZE_LOAD = SW'(SNOOZE_TICKS);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_RINGING  = 2'd2,
        ST_SNOOZING = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [RW-1:0]   r_ring_cnt;
    logic [RW-1:0]   w_ring_cnt_nxt;
    logic [SW-1:0]   r_snooze_cnt;
    logic [SW-1:0]   w_snooze_cnt_nxt;
    logic            r_match_d;
    logic            w_match;
    logic            w_trigger;
    logic            r_ringing;
    logic            r_snooze_active;
    logic            r_buzzer;
    logic            w_buzzer_nxt;

    // Edge-detect the time match so a held 07:30:00 fires only once.
    assign w_match   = (hours == alarm_hours) && (minutes == alarm_minutes) && (seconds == 6'd0);
    assign w_trigger = w_match && !r_match_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_DISARMED;
            r_ring_cnt      <= '0;
            r_snooze_cnt    <= '0;
            r_match_d       <= 1'b0;
            r_ringing       <= 1'b0;
            r_snooze_active <= 1'b0;
            r_buzzer        <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_ring_cnt      <= w_ring_cnt_nxt;
            r_snooze_cnt    <= w_snooze_cnt_nxt;
            r_match_d       <= w_match;
            r_ringing       <= (w_state_nxt == ST_RINGING);
            r_snooze_active <= (w_state_nxt == ST_SNOOZING);
            r_buzzer        <= w_buzzer_nxt;
        end
    end

    // Priority: alarm_en low > stop > snooze > trigger/timeout.
    always_comb begin
        w_state_nxt      = r_state;
        w_ring_cnt_nxt   = r_ring_cnt;
        w_snooze_cnt_nxt = r_snooze_cnt;
        if (!alarm_en) begin
            w_state_nxt      = ST_DISARMED;
            w_ring_cnt_nxt   = '0;
            w_snooze_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_DISARMED: begin
                    // A match already high when arming is swallowed by r_match_d.
                    w_state_nxt      = ST_ARMED;
                    w_ring_cnt_nxt   = '0;
                    w_snooze_cnt_nxt = '0;
                end
                ST_ARMED: begin
                    w_ring_cnt_nxt   = '0;
                    w_snooze_cnt_nxt = '0;
                    if (w_trigger) begin
                        w_state_nxt = ST_RINGING;
                    end
                end
                ST_RINGING: begin
                    if (stop_btn) begin
                        w_state_nxt      = ST_ARMED;
                        w_ring_cnt_nxt   = '0;
                        w_snooze_cnt_nxt = '0;
                    end else if (snooze_btn) begin
                        w_state_nxt      = ST_SNOOZING;
                        w_ring_cnt_nxt   = '0;
                        w_snooze_cnt_nxt = SNOOZE_LOAD;
                    end else if (sec_tick) begin
                        if (r_ring_cnt == RING_LAST) begin
                            w_state_nxt      = ST_ARMED;
                            w_ring_cnt_nxt   = '0;
                            w_snooze_cnt_nxt = '0;
                        end else if (r_ring_cnt < RING_MAX) begin
                            w_ring_cnt_nxt = r_ring_cnt + RW'(1);
                        end
                    end
                end
                ST_SNOOZING: begin
                    // snooze_btn and trigger are deliberately not looked at here.
                    if (stop_btn) begin
                        w_state_nxt      = ST_ARMED;
                        w_ring_cnt_nxt   = '0;
                        w_snooze_cnt_nxt = '0;
                    end else if (sec_tick) begin
                        if (r_snooze_cnt == SW'(1)) begin
                            w_state_nxt      = ST_RINGING;
                            w_ring_cnt_nxt   = '0;
                            w_snooze_cnt_nxt = '0;
                        end else if (r_snooze_cnt != '0) begin
                            w_snooze_cnt_nxt = r_snooze_cnt - SW'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt      = ST_DISARMED;
                    w_ring_cnt_nxt   = '0;
                    w_snooze_cnt_nxt = '0;
                end
            endcase
        end
    end

`ifdef ALARM_BUZZER_PULSE_EN
    // Start high on RINGING entry, then toggle per tick for a 0.5 Hz tone.
    always_comb begin
        w_buzzer_nxt = 1'b0;
        if (w_state_nxt == ST_RINGING) begin
            if (r_state != ST_RINGING) begin
                w_buzzer_nxt = 1'b1;
            end else if (sec_tick) begin
                w_buzzer_nxt = !r_buzzer;
            end else begin
                w_buzzer_nxt = r_buzzer;
            end
        end
    end
`else
    always_comb begin
        w_buzzer_nxt = (w_state_nxt == ST_RINGING);
    end
`endif

    assign ringing       = r_ringing;
    assign snooze_active = r_snooze_active;
    assign buzzer        = r_buzzer;

endmodule
